dif_butterfly: RTL and testbench

- Radix-2 decimation-in-frequency (Gentleman-Sande) butterfly: P = A + B, Q = (A − B)·W, where W is either the twiddle or its conjugate.
- Mirror of the DIT butterfly. It builds the IFFT / synthesis path of the beamformer, taking steered frequency bins back to time domain; the forward DIF path reuses it with inv=0.
- Streams one butterfly per cycle under a valid/ready handshake.
- Supports per-sample ½ scaling, rounding, saturation and a sticky overflow flag.

---
 rtl/fft_pkg.sv | 40 ++++
 rtl/cmult_pipe.sv | 55 +++++
 rtl/dif_butterfly.sv | 150 +++++++++++++++
 tb/tb_dif_butterfly.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Fixed-point helpers shared by the FFT butterflies and the FFT controller:
// round-half-up arithmetic shift and saturation to the DW-bit signed range.
package fft_pkg;

    localparam int DW_DEF = 16;
    localparam int Q_FRAC = 15;
    localparam int WIDE   = 2 * DW_DEF + 4;

    localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-DW_DEF+1){1'b0}}, {(DW_DEF-1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_MIN = {{(WIDE-DW_DEF+1){1'b1}}, {(DW_DEF-1){1'b0}}};

    typedef struct packed {
        logic [DW_DEF-1:0] val;
        logic              clip;
    } sat_t;

    function automatic sat_t sat_dw(input logic signed [WIDE-1:0] x);
        sat_t r;
        if (x > SAT_MAX) begin
            r.val  = SAT_MAX[DW_DEF-1:0];
            r.clip = 1'b1;
        end else if (x < SAT_MIN) begin
            r.val  = SAT_MIN[DW_DEF-1:0];
            r.clip = 1'b1;
        end else begin
            r.val  = x[DW_DEF-1:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

    // Adding half an LSB before the arithmetic shift gives round-half-up.
    function automatic logic signed [WIDE-1:0] rnd_shift(input logic signed [WIDE-1:0] x,
                                                         input logic [4:0] sh);
        logic signed [WIDE-1:0] bias;
        bias = (sh == 5'd0) ? '0 : (WIDE'(1) << (sh - 5'd1));
        return (x + bias) >>> sh;
    endfunction

endpackage

// File: rtl/cmult_pipe.sv
// Registered complex multiply producing the four full-precision partial
// products of a*b or a*conj(b); the caller combines them.
module cmult_pipe #(
    parameter int AW = 17,
    parameter int BW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [AW-1:0]    ar,
    input  logic signed [AW-1:0]    ai,
    input  logic signed [BW-1:0]    br,
    input  logic signed [BW-1:0]    bi,
    input  logic                    conj,
    output logic signed [AW+BW-1:0] p_rr,
    output logic signed [AW+BW-1:0] p_ii,
    output logic signed [AW+BW-1:0] p_ri,
    output logic signed [AW+BW-1:0] p_ir
);

    localparam int PW = AW + BW;
    localparam logic signed [BW-1:0] B_MIN = {1'b1, {(BW-1){1'b0}}};
    localparam logic signed [BW-1:0] B_MAX = {1'b0, {(BW-1){1'b1}}};

    logic signed [BW-1:0] bi_eff;
    logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;

    // Negating the most negative code would wrap, so it clips to the maximum.
    always_comb begin
        bi_eff = bi;
        if (conj) begin
            bi_eff = (bi == B_MIN) ? B_MAX : -bi;
        end
    end

    assign ar_x = {{BW{ar[AW-1]}}, ar};
    assign ai_x = {{BW{ai[AW-1]}}, ai};
    assign br_x = {{AW{br[BW-1]}}, br};
    assign bi_x = {{AW{bi_eff[BW-1]}}, bi_eff};

    always_ff @(posedge clk) begin
        if (rst) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
        end else if (en) begin
            p_rr <= ar_x * br_x;
            p_ii <= ai_x * bi_x;
            p_ri <= ar_x * bi_x;
            p_ir <= ai_x * br_x;
        end
    end

endmodule

// File: rtl/dif_butterfly.sv
// Radix-2 DIF butterfly: P = A + B, Q = (A - B) * W (or conj(W) for the IFFT),
// three-stage pipeline with a stall-everything valid/ready handshake.
module dif_butterfly
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic signed [DW-1:0] ar,
    input  logic signed [DW-1:0] ai,
    input  logic signed [DW-1:0] br,
    input  logic signed [DW-1:0] bi,
    input  logic signed [DW-1:0] wr,
    input  logic signed [DW-1:0] wi,
    input  logic                 inv,
    input  logic                 scale,
    output logic signed [DW-1:0] pr,
    output logic signed [DW-1:0] pi,
    output logic signed [DW-1:0] qr,
    output logic signed [DW-1:0] qi,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic                 ovf,
    input  logic                 clr_ovf
);

    localparam int XW = DW + 1;
    localparam int PW = 2 * DW + 1;

    logic en;

    logic signed [XW-1:0] sr1, si1, dr1, di1;
    logic signed [DW-1:0] wr1, wi1;
    logic                 inv1, scale1, v1;

    logic signed [XW-1:0] sr2, si2;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                 scale2, v2;

    logic signed [WIDE-1:0] pr_w, pi_w, qr_w, qi_w;
    logic [4:0]             sh_p, sh_q;
    sat_t                   pr_s, pi_s, qr_s, qi_s;
    logic                   clip_any;

    assign en       = !valid_out | ready_out;
    assign ready_in = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr1    <= '0;
            si1    <= '0;
            dr1    <= '0;
            di1    <= '0;
            wr1    <= '0;
            wi1    <= '0;
            inv1   <= 1'b0;
            scale1 <= 1'b0;
            v1     <= 1'b0;
        end else if (en) begin
            sr1    <= {ar[DW-1], ar} + {br[DW-1], br};
            si1    <= {ai[DW-1], ai} + {bi[DW-1], bi};
            dr1    <= {ar[DW-1], ar} - {br[DW-1], br};
            di1    <= {ai[DW-1], ai} - {bi[DW-1], bi};
            wr1    <= wr;
            wi1    <= wi;
            inv1   <= inv;
            scale1 <= scale;
            v1     <= valid_in;
        end
    end

    cmult_pipe #(
        .AW(XW),
        .BW(DW)
    ) u_cmult (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .ar  (dr1),
        .ai  (di1),
        .br  (wr1),
        .bi  (wi1),
        .conj(inv1),
        .p_rr(p_rr),
        .p_ii(p_ii),
        .p_ri(p_ri),
        .p_ir(p_ir)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sr2    <= '0;
            si2    <= '0;
            scale2 <= 1'b0;
            v2     <= 1'b0;
        end else if (en) begin
            sr2    <= sr1;
            si2    <= si1;
            scale2 <= scale1;
            v2     <= v1;
        end
    end

    assign pr_w = {{(WIDE-XW){sr2[XW-1]}}, sr2};
    assign pi_w = {{(WIDE-XW){si2[XW-1]}}, si2};
    assign qr_w = {{(WIDE-PW){p_rr[PW-1]}}, p_rr} - {{(WIDE-PW){p_ii[PW-1]}}, p_ii};
    assign qi_w = {{(WIDE-PW){p_ri[PW-1]}}, p_ri} + {{(WIDE-PW){p_ir[PW-1]}}, p_ir};

    // Q carries the Q1.15 twiddle fraction, so it drops Q_FRAC more bits than P.
    assign sh_p = {4'b0000, scale2};
    assign sh_q = 5'(Q_FRAC) + {4'b0000, scale2};

    assign pr_s = sat_dw(rnd_shift(pr_w, sh_p));
    assign pi_s = sat_dw(rnd_shift(pi_w, sh_p));
    assign qr_s = sat_dw(rnd_shift(qr_w, sh_q));
    assign qi_s = sat_dw(rnd_shift(qi_w, sh_q));

    assign clip_any = pr_s.clip | pi_s.clip | qr_s.clip | qi_s.clip;

    always_ff @(posedge clk) begin
        if (rst) begin
            pr        <= '0;
            pi        <= '0;
            qr        <= '0;
            qi        <= '0;
            valid_out <= 1'b0;
        end else if (en) begin
            pr        <= pr_s.val;
            pi        <= pi_s.val;
            qr        <= qr_s.val;
            qi        <= qi_s.val;
            valid_out <= v2;
        end
    end

    // Only real beats entering the output register may set the flag; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (en && v2 && clip_any) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dif_butterfly.sv
// Self-checking bench for dif_butterfly: directed cases plus randomized
// streaming against an arithmetic reference model and a scoreboard queue.
module tb_dif_butterfly;

    logic clk = 1'b0;
    logic rst, valid_in, ready_in, inv, scale, valid_out, ready_out, ovf, clr_ovf;
    logic signed [15:0] ar, ai, br, bi, wr, wi, pr, pi, qr, qi;

    typedef struct {
        int pr;
        int pi;
        int qr;
        int qi;
        bit clip;
    } exp_t;

    exp_t sb[$];
    bit   ovfExp;
    int   vectors;
    int   miscompares;
    bit   stopRand;

    dif_butterfly #(.DW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .ar       (ar),
        .ai       (ai),
        .br       (br),
        .bi       (bi),
        .wr       (wr),
        .wi       (wi),
        .inv      (inv),
        .scale    (scale),
        .pr       (pr),
        .pi       (pi),
        .qr       (qr),
        .qi       (qi),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .ovf      (ovf),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Round half-up then floor-divide by 2^sh.
    function automatic longint roundDiv(input longint x, input int sh);
        longint half;
        half = (sh > 0) ? (longint'(1) <<< (sh - 1)) : 0;
        return (x + half) >>> sh;
    endfunction

    function automatic exp_t model(input int a_r, input int a_i, input int b_r, input int b_i,
                                   input int w_r, input int w_i, input bit iv, input bit sc);
        exp_t   e;
        longint wEff, dR, dI, pR, pI, qR, qI;
        wEff = iv ? -longint'(w_i) : longint'(w_i);
        if (wEff > 32767) wEff = 32767;
        dR = a_r - b_r;
        dI = a_i - b_i;
        pR = roundDiv(longint'(a_r + b_r), int'(sc));
        pI = roundDiv(longint'(a_i + b_i), int'(sc));
        qR = roundDiv(dR * w_r - dI * wEff, 15 + int'(sc));
        qI = roundDiv(dR * wEff + dI * w_r, 15 + int'(sc));
        e.pr = int'(clamp16(pR));
        e.pi = int'(clamp16(pI));
        e.qr = int'(clamp16(qR));
        e.qi = int'(clamp16(qI));
        e.clip = (clamp16(pR) != pR) || (clamp16(pI) != pI) ||
                 (clamp16(qR) != qR) || (clamp16(qI) != qI);
        return e;
    endfunction

    // Scoreboard: push on input transfer, compare head while valid_out, pop on output transfer.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            ovfExp = 1'b0;
        end else begin
            if (valid_out) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_valid_out", longint'(valid_out), 0);
                end else begin
                    checkOutput("sb_pr", longint'(pr), longint'(sb[0].pr));
                    checkOutput("sb_pi", longint'(pi), longint'(sb[0].pi));
                    checkOutput("sb_qr", longint'(qr), longint'(sb[0].qr));
                    checkOutput("sb_qi", longint'(qi), longint'(sb[0].qi));
                    if (ready_out) begin
                        if (sb[0].clip) ovfExp = 1'b1;
                        checkOutput("sb_ovf", longint'(ovf), longint'(ovfExp));
                        void'(sb.pop_front());
                    end
                end
            end
            if (clr_ovf) ovfExp = 1'b0;
            if (valid_in && ready_in) begin
                sb.push_back(model(int'(ar), int'(ai), int'(br), int'(bi),
                                   int'(wr), int'(wi), inv, scale));
            end
        end
    end

    task automatic setInputs(input int a_r, input int a_i, input int b_r, input int b_i,
                             input int w_r, input int w_i, input bit iv, input bit sc);
        ar    = 16'(a_r);
        ai    = 16'(a_i);
        br    = 16'(b_r);
        bi    = 16'(b_i);
        wr    = 16'(w_r);
        wi    = 16'(w_i);
        inv   = iv;
        scale = sc;
    endtask

    task automatic applyStimulus(input int a_r, input int a_i, input int b_r, input int b_i,
                                 input int w_r, input int w_i, input bit iv, input bit sc);
        bit done;
        int waited;
        setInputs(a_r, a_i, b_r, b_i, w_r, w_i, iv, sc);
        valid_in = 1'b1;
        done = 1'b0;
        waited = 0;
        while (!done && waited < 100) begin
            @(negedge clk);
            done = ready_in;
            @(posedge clk);
            #1;
            waited++;
        end
        valid_in = 1'b0;
        checkOutput("xfer_done", longint'(done), 1);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectOut(input string tag, input int epr, input int epi, input int eqr,
                             input int eqi, input bit eovf);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_out) break;
        end
        checkOutput({tag, "_valid"}, longint'(valid_out), 1);
        checkOutput({tag, "_pr"}, longint'(pr), longint'(epr));
        checkOutput({tag, "_pi"}, longint'(pi), longint'(epi));
        checkOutput({tag, "_qr"}, longint'(qr), longint'(eqr));
        checkOutput({tag, "_qi"}, longint'(qi), longint'(eqi));
        checkOutput({tag, "_ovf"}, longint'(ovf), longint'(eovf));
        @(posedge clk);
        #1;
    endtask

    function automatic int randVal();
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel == 0) return -32768;
        if (sel == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int smallVal();
        return int'($urandom_range(0, 8000)) - 4000;
    endfunction

    task automatic drain();
        ready_out = 1'b1;
        for (int i = 0; i < 50 && sb.size() > 0; i++) idleCycles(1);
        checkOutput("drain_empty", longint'(sb.size()), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit pattern[12];
        bit obs[15];

        vectors = 0;
        miscompares = 0;
        ovfExp = 1'b0;
        rst = 1'b1;
        valid_in = 1'b0;
        ready_out = 1'b1;
        clr_ovf = 1'b0;
        setInputs(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        idleCycles(3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid_out", longint'(valid_out), 0);
        checkOutput("rst_pr", longint'(pr), 0);
        checkOutput("rst_qi", longint'(qi), 0);
        checkOutput("rst_ovf", longint'(ovf), 0);
        checkOutput("rst_ready_in", longint'(ready_in), 1);
        idleCycles(1);

        $display("[TB] directed cases");
        applyStimulus(16384, 0, 8192, 0, 32767, 0, 1'b0, 1'b0);
        expectOut("fwd", 24576, 0, 8192, 0, 1'b0);
        applyStimulus(0, 0, -16384, 0, 0, -32768, 1'b1, 1'b0);
        expectOut("inv", -16384, 0, 0, 16384, 1'b0);
        applyStimulus(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0);
        expectOut("sat", 32767, 0, 0, 0, 1'b1);
        idleCycles(3);
        checkOutput("sat_sticky", longint'(ovf), 1);
        clr_ovf = 1'b1;
        idleCycles(1);
        clr_ovf = 1'b0;
        checkOutput("clr_ovf", longint'(ovf), 0);
        applyStimulus(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b1);
        expectOut("sat_scaled", 32767, 0, 0, 0, 1'b0);

        // Clear held across the edge where a clipping beat lands: the set must win.
        applyStimulus(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0);
        clr_ovf = 1'b1;
        idleCycles(2);
        clr_ovf = 1'b0;
        checkOutput("set_wins", longint'(ovf), 1);
        clr_ovf = 1'b1;
        idleCycles(1);
        clr_ovf = 1'b0;
        idleCycles(2);

        $display("[TB] bubbles");
        for (int i = 0; i < 12; i++) pattern[i] = (i % 2 == 0);
        for (int i = 0; i < 15; i++) begin
            if (i < 12 && pattern[i]) begin
                setInputs(smallVal(), smallVal(), smallVal(), smallVal(),
                          randVal(), randVal(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                setInputs(32767, 32767, 32767, 32767, 32767, 32767, 1'b0, 1'b0);
            end
            valid_in = (i < 12) ? pattern[i] : 1'b0;
            @(negedge clk);
            obs[i] = valid_out;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("bubble_pattern_%0d", i), longint'(obs[i + 3]), longint'(pattern[i]));
        end
        checkOutput("bubble_ovf", longint'(ovf), 0);
        drain();

        $display("[TB] back-pressure");
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(randVal(), randVal(), randVal(), randVal(), randVal(), randVal(),
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            begin
                idleCycles(2);
                ready_out = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (i >= 2) begin
                        checkOutput("stall_valid_out", longint'(valid_out), 1);
                        checkOutput("stall_ready_in", longint'(ready_in), 0);
                    end
                    @(posedge clk);
                    #1;
                end
                ready_out = 1'b1;
            end
        join
        drain();

        $display("[TB] random streaming");
        stopRand = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    if ($urandom_range(0, 3) == 0) idleCycles(1);
                    applyStimulus(randVal(), randVal(), randVal(), randVal(), randVal(), randVal(),
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                stopRand = 1'b1;
            end
            begin
                while (!stopRand) begin
                    ready_out = ($urandom_range(0, 3) != 0);
                    idleCycles(1);
                end
                ready_out = 1'b1;
            end
        join
        drain();

        $display("[TB] mid-stream reset");
        applyStimulus(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0);
        applyStimulus(smallVal(), smallVal(), smallVal(), smallVal(), randVal(), randVal(), 1'b0, 1'b0);
        applyStimulus(smallVal(), smallVal(), smallVal(), smallVal(), randVal(), randVal(), 1'b1, 1'b0);
        checkOutput("pre_rst_ovf", longint'(ovf), 1);
        rst = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_valid_out", longint'(valid_out), 0);
        checkOutput("mid_rst_pr", longint'(pr), 0);
        checkOutput("mid_rst_pi", longint'(pi), 0);
        checkOutput("mid_rst_qr", longint'(qr), 0);
        checkOutput("mid_rst_qi", longint'(qi), 0);
        checkOutput("mid_rst_ovf", longint'(ovf), 0);
        idleCycles(1);
        applyStimulus(1000, -2000, 300, 400, 23170, -23170, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_lat1", longint'(valid_out), 0);
        @(negedge clk);
        checkOutput("post_rst_lat2", longint'(valid_out), 0);
        @(negedge clk);
        checkOutput("post_rst_lat3", longint'(valid_out), 1);
        idleCycles(1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
